serial_result_collector: RTL

SERIAL_RESULT_COLLECTOR -- requirements
Module: serial_result_collector

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/sipo_shift_reg.sv | 22 ++
 rtl/serial_result_collector.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder slice.
// State encodings and default widths.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VALID   = 2'b10
  } col_state_e;

  typedef enum logic [1:0] {
    ADD_IDLE = 2'b00,
    ADD_RUN  = 2'b01,
    ADD_DONE = 2'b10
  } add_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out register.
// Bits enter at the MSB and move toward the LSB.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // clear wins; otherwise shift right with din into the MSB
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_result_collector.sv
// Collects serial adder sum bits into a word.
// Flags short and overrun collections.
module serial_result_collector
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             sum_bit,
  input  logic             carry_bit,
  input  logic             done,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             result_valid,
  output logic             error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  col_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  logic          ovr_q, ovr_d;
  logic          err_q, err_d;
  logic          shift_en;
  logic          clear;

  assign clear = rst | load;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk     (clk),
    .clear   (clear),
    .shift_en(shift_en),
    .din     (sum_bit),
    .q       (result)
  );

  // state, count and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  // next state, slot acceptance and error evaluation
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    ovr_d    = ovr_q;
    err_d    = err_q;
    shift_en = 1'b0;
    if (load) begin
      state_d = COLLECT;
      count_d = '0;
      carry_d = 1'b0;
      ovr_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COLLECT: begin
          if (enable) begin
            if (count_q < FULL) begin
              shift_en = 1'b1;
              count_d  = count_q + CW'(1);
              carry_d  = carry_bit;
            end else begin
              ovr_d = 1'b1;
            end
          end
          if (done) begin
            state_d = VALID;
            err_d   = ovr_d | (count_d != FULL);
          end
        end
        VALID: begin
          if (result_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign carry_out    = carry_q;
  assign error        = err_q;
  assign busy         = (state_q == COLLECT);
  assign result_valid = (state_q == VALID);

endmodule
